btn_conditioner: RTL

- Per-button input conditioning stage feeding the counter/display core's control inputs (enable, direction, speed up/down).
- Turns one raw, bouncy, asynchronous push-button into clean outputs: a debounced level, one-cycle press/release pulses, a long-press pulse and optional auto-repeat press pulses while held.
- One instance per button; all outputs are synchronous to clk.

---
 rtl/btn_if.sv | 12 +
 rtl/btn_conditioner.sv | 104 ++++++++++
 2 files changed

// File: rtl/btn_if.sv
// btn_if: raw button input, repeat enable and the conditioned outputs of one button.
interface btn_if;
   logic pb;
   logic repeat_en;
   logic level;
   logic press_pulse;
   logic release_pulse;
   logic long_press;
   logic held;
   modport master (output pb, repeat_en, input level, press_pulse, release_pulse, long_press, held);
   modport slave (input pb, repeat_en, output level, press_pulse, release_pulse, long_press, held);
endinterface

// File: rtl/btn_conditioner.sv
// btn_conditioner: synchronize, debounce and classify one push-button (press/release/long/repeat).
// Define BTN_REPEAT_ACCEL_EN to halve the repeat interval after 8 repeats in one episode.
module btn_conditioner #(
   parameter int DB_CYCLES     = 4,
   parameter int HOLD_CYCLES   = 50_000_000,
   parameter int REPEAT_CYCLES = 10_000_000
) (
   input logic clk,
   input logic rst,
   btn_if.slave b
);
   localparam int DW   = $clog2(DB_CYCLES + 1);
   localparam int TMAX = HOLD_CYCLES > REPEAT_CYCLES ? HOLD_CYCLES : REPEAT_CYCLES;
   localparam int TW   = $clog2(TMAX + 1);
   typedef enum logic [1:0] {IDLE, PRESS, HELD, REPEAT} state_t;
   state_t state_q, state_d;
   logic s1_q, s2_q;
   logic level_q, level_d;
   logic [DW-1:0] db_q, db_d;
   logic [TW-1:0] timer_q, timer_d, ival_m1;
   logic press_q, press_d, release_q, release_d, long_q, long_d, held_q, held_d;
   logic mis, hit, rise, fall;
`ifdef BTN_REPEAT_ACCEL_EN
   localparam int FAST = REPEAT_CYCLES / 2 > 1 ? REPEAT_CYCLES / 2 : 1;
   logic [3:0] rcnt_q, rcnt_d;
   assign ival_m1 = rcnt_q[3] ? TW'(FAST - 1) : TW'(REPEAT_CYCLES - 1);
   assign rcnt_d  = state_d != REPEAT ? 4'd0 :
                    (press_d && state_q == REPEAT && !rcnt_q[3]) ? rcnt_q + 4'd1 : rcnt_q;
`else
   assign ival_m1 = TW'(REPEAT_CYCLES - 1);
`endif
   always_comb begin
      mis     = s2_q ^ level_q;
      hit     = mis && db_q == DW'(DB_CYCLES - 1);
      level_d = level_q ^ hit;
      db_d    = (mis && !hit) ? db_q + 1'b1 : '0;
      rise    = level_d & ~level_q;
      fall    = level_q & ~level_d;
   end
   // level is high exactly when the FSM is outside IDLE, so a fall always means release
   always_comb begin
      state_d   = state_q;
      timer_d   = &timer_q ? timer_q : timer_q + 1'b1;
      press_d   = 1'b0;
      long_d    = 1'b0;
      release_d = fall;
      held_d    = state_q == HELD || state_q == REPEAT;
      if (fall) state_d = IDLE;
      else
         case (state_q)
            IDLE: begin
               press_d = rise;
               state_d = rise ? PRESS : IDLE;
            end
            PRESS: if (timer_q == TW'(HOLD_CYCLES - 1)) begin
               long_d  = 1'b1;
               press_d = b.repeat_en;
               state_d = b.repeat_en ? REPEAT : HELD;
            end
            HELD: state_d = b.repeat_en ? REPEAT : HELD;
            REPEAT: begin
               state_d = b.repeat_en ? REPEAT : HELD;
               press_d = b.repeat_en && timer_q == ival_m1;
               timer_d = press_d ? '0 : timer_d;
            end
         endcase
      timer_d = state_d != state_q ? '0 : timer_d;
   end
   always_ff @(posedge clk or posedge rst)
      if (rst) begin
         s1_q      <= 1'b0;
         s2_q      <= 1'b0;
         level_q   <= 1'b0;
         db_q      <= '0;
         state_q   <= IDLE;
         timer_q   <= '0;
         press_q   <= 1'b0;
         release_q <= 1'b0;
         long_q    <= 1'b0;
         held_q    <= 1'b0;
`ifdef BTN_REPEAT_ACCEL_EN
         rcnt_q    <= '0;
`endif
      end else begin
         s1_q      <= b.pb;
         s2_q      <= s1_q;
         level_q   <= level_d;
         db_q      <= db_d;
         state_q   <= state_d;
         timer_q   <= timer_d;
         press_q   <= press_d;
         release_q <= release_d;
         long_q    <= long_d;
         held_q    <= held_d;
`ifdef BTN_REPEAT_ACCEL_EN
         rcnt_q    <= rcnt_d;
`endif
      end
   assign b.level         = level_q;
   assign b.press_pulse   = press_q;
   assign b.release_pulse = release_q;
   assign b.long_press    = long_q;
   assign b.held          = held_q;
endmodule
